seq_divider: RTL and testbench

- Multi-cycle radix-2 restoring divider; replaces the linear-search divider (latency proportional to the quotient) with fixed latency of WIDTH+1 clocks.
- Produces quotient and remainder, with optional signed mode and a divide-by-zero flag.
- Used by datapath blocks needing integer division without a combinational divider; start/done handshake lets the caller issue back-to-back operations.

---
 rtl/div_pkg.sv | 21 ++
 rtl/seq_divider_step.sv | 27 ++
 rtl/seq_divider.sv | 127 ++++++++++++
 tb/tb_seq_divider.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential divide datapath: FSM states, counter sizing
// and a magnitude helper meant for reuse by other multiply/divide blocks.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } div_state_t;

    localparam int DIV_WIDTH = 16;
    localparam int CNT_W     = $clog2(DIV_WIDTH);

    // Callers sign-extend into this width and truncate the result back to their own.
    localparam int ABS_MAX_W = 64;

    function automatic logic [ABS_MAX_W-1:0] abs_val(input logic [ABS_MAX_W-1:0] x);
        return x[ABS_MAX_W-1] ? -x : x;
    endfunction

endpackage

// File: rtl/seq_divider_step.sv
// One restoring-division iteration: shift {partial remainder, dividend} left,
// trial-subtract the divisor, keep the difference only when it is non-negative.
module seq_divider_step
    import div_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic [WIDTH-1:0] dvd_in,
    input  logic [WIDTH-1:0] dsr_in,
    output logic [WIDTH:0]   rem_out,
    output logic [WIDTH-1:0] dvd_out
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;
    logic             trial_neg;

    // One extra guard bit so the sign of the trial difference is never lost.
    assign shifted   = {rem_in, dvd_in[WIDTH-1]};
    assign trial     = shifted - {2'b00, dsr_in};
    assign trial_neg = trial[WIDTH+1];

    assign rem_out = trial_neg ? shifted[WIDTH:0] : trial[WIDTH:0];
    assign dvd_out = {dvd_in[WIDTH-2:0], ~trial_neg};

endmodule

// File: rtl/seq_divider.sv
// Fixed-latency radix-2 restoring divider with start/done handshake, optional
// two's-complement operands (truncating toward zero) and a divide-by-zero flag.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH  = DIV_WIDTH,
    parameter bit SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_BITS = $clog2(WIDTH);

    div_state_t          state_reg, state_next;
    logic [WIDTH:0]      rem_reg;
    logic [WIDTH-1:0]    dvd_reg;
    logic [WIDTH-1:0]    dsr_reg;
    logic [CNT_BITS-1:0] cnt_reg;
    logic                q_neg_reg, r_neg_reg;
    logic [WIDTH-1:0]    quotient_reg, remainder_reg;
    logic                dbz_reg, done_reg;

    logic [WIDTH-1:0]    dividend_mag, divisor_mag;
    logic                dividend_neg, divisor_neg;
    logic [WIDTH:0]      rem_step;
    logic [WIDTH-1:0]    dvd_step;

    generate
        if (SIGNED) begin : g_signed
            assign dividend_mag = WIDTH'(abs_val(ABS_MAX_W'($signed(dividend))));
            assign divisor_mag  = WIDTH'(abs_val(ABS_MAX_W'($signed(divisor))));
            assign dividend_neg = dividend[WIDTH-1];
            assign divisor_neg  = divisor[WIDTH-1];
        end else begin : g_unsigned
            assign dividend_mag = dividend;
            assign divisor_mag  = divisor;
            assign dividend_neg = 1'b0;
            assign divisor_neg  = 1'b0;
        end
    endgenerate

    seq_divider_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_reg),
        .dvd_in  (dvd_reg),
        .dsr_in  (dsr_reg),
        .rem_out (rem_step),
        .dvd_out (dvd_step)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start && divisor != '0) state_next = RUN;
            RUN:     if (cnt_reg == '0) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            rem_reg       <= '0;
            dvd_reg       <= '0;
            dsr_reg       <= '0;
            cnt_reg       <= '0;
            q_neg_reg     <= 1'b0;
            r_neg_reg     <= 1'b0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            dbz_reg       <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            // Zero divisor completes immediately without leaving IDLE.
                            quotient_reg  <= '1;
                            remainder_reg <= dividend;
                            dbz_reg       <= 1'b1;
                            done_reg      <= 1'b1;
                        end else begin
                            rem_reg   <= '0;
                            dvd_reg   <= dividend_mag;
                            dsr_reg   <= divisor_mag;
                            cnt_reg   <= CNT_BITS'(WIDTH - 1);
                            q_neg_reg <= dividend_neg ^ divisor_neg;
                            r_neg_reg <= dividend_neg;
                        end
                    end
                end
                RUN: begin
                    rem_reg <= rem_step;
                    dvd_reg <= dvd_step;
                    cnt_reg <= cnt_reg - CNT_BITS'(1);
                end
                FINISH: begin
                    // MIN / -1 wraps back to MIN here, which is the intended overflow result.
                    quotient_reg  <= q_neg_reg ? -dvd_reg : dvd_reg;
                    remainder_reg <= r_neg_reg ? -rem_reg[WIDTH-1:0] : rem_reg[WIDTH-1:0];
                    dbz_reg       <= 1'b0;
                    done_reg      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy        = (state_reg != IDLE);
    assign done        = done_reg;
    assign quotient    = quotient_reg;
    assign remainder   = remainder_reg;
    assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_seq_divider.sv
// Drives an unsigned and a signed 16-bit divider with identical stimulus and checks
// both every cycle against an arithmetic model, plus directed literal cases.
module tb_seq_divider;

    localparam int W = 16;

    typedef struct packed {
        logic          z;
        logic [W-1:0]  q;
        logic [W-1:0]  r;
    } res_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy [2];
    logic         done [2];
    logic         dbz [2];
    logic [W-1:0] quo [2];
    logic [W-1:0] rem [2];

    int n_checks = 0;
    int n_pass = 0;

    seq_divider #(.WIDTH(W), .SIGNED(1'b0)) u_uns (
        .clk(clk), .reset(reset), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy[0]), .done(done[0]), .quotient(quo[0]), .remainder(rem[0]),
        .div_by_zero(dbz[0])
    );

    seq_divider #(.WIDTH(W), .SIGNED(1'b1)) u_sgn (
        .clk(clk), .reset(reset), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy[1]), .done(done[1]), .quotient(quo[1]), .remainder(rem[1]),
        .div_by_zero(dbz[1])
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    endtask

    // Reference arithmetic: plain / and % on 32-bit ints (truncate toward zero).
    function automatic res_t ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn);
        res_t res;
        int   sa, sb, qi, ri;
        if (b == '0) begin
            res.z = 1'b1;
            res.q = '1;
            res.r = a;
            return res;
        end
        res.z = 1'b0;
        if (!sgn) begin
            res.q = a / b;
            res.r = a % b;
        end else begin
            sa = int'($signed(a));
            sb = int'($signed(b));
            qi = sa / sb;
            ri = sa % sb;
            res.q = qi[W-1:0];
            res.r = ri[W-1:0];
        end
        return res;
    endfunction

    // Transaction-level model: one outstanding operation, due WIDTH+1 edges after acceptance.
    int           cyc = 0;
    bit           pend = 1'b0;
    int           due = 0;
    res_t         pres [2];
    res_t         eres [2];
    bit           edone = 1'b0;
    int           ebusy = 0;
    bit           model_valid = 1'b0;

    initial begin
        res_t zero_res;
        zero_res = '0;
        eres[0] = zero_res;
        eres[1] = zero_res;
        forever begin
            @(posedge clk);
            cyc++;
            edone = 1'b0;
            if (reset) begin
                pend = 1'b0;
                eres[0] = zero_res;
                eres[1] = zero_res;
            end else begin
                bit blocked;
                blocked = pend;
                if (pend && due == cyc) begin
                    edone = 1'b1;
                    eres[0] = pres[0];
                    eres[1] = pres[1];
                    pend = 1'b0;
                end
                if (start && !blocked) begin
                    for (int m = 0; m < 2; m++) pres[m] = ref_div(dividend, divisor, m[0]);
                    if (divisor == '0) begin
                        edone = 1'b1;
                        eres[0] = pres[0];
                        eres[1] = pres[1];
                    end else begin
                        pend = 1'b1;
                        due = cyc + W + 1;
                    end
                end
            end
            // Busy is only pinned where its meaning is unambiguous; the finishing cycle is skipped.
            if (!pend) ebusy = 0;
            else if (due - cyc >= 2) ebusy = 1;
            else ebusy = -1;
            model_valid = 1'b1;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (model_valid) begin
                for (int m = 0; m < 2; m++) begin
                    check($sformatf("cyc%0d done[%0d]", cyc, m), 32'(done[m]), 32'(edone));
                    check($sformatf("cyc%0d quotient[%0d]", cyc, m), 32'(quo[m]), 32'(eres[m].q));
                    check($sformatf("cyc%0d remainder[%0d]", cyc, m), 32'(rem[m]), 32'(eres[m].r));
                    check($sformatf("cyc%0d div_by_zero[%0d]", cyc, m), 32'(dbz[m]), 32'(eres[m].z));
                    if (ebusy >= 0)
                        check($sformatf("cyc%0d busy[%0d]", cyc, m), 32'(busy[m]), 32'(ebusy));
                end
            end
        end
    end

    // Start must already be driven; returns edges after the sampling edge until done.
    task automatic wait_done(input int inject_at, output int k, output int busy_hi);
        @(posedge clk);
        k = 0;
        busy_hi = 0;
        @(negedge clk);
        start = 1'b0;
        if (busy[0]) busy_hi++;
        while (!done[0] && k < 40) begin
            @(posedge clk);
            @(negedge clk);
            k++;
            start = (k == inject_at);
            if (k == inject_at) begin
                dividend = 16'd3;
                divisor  = 16'd3;
            end
            if (k < W && busy[0]) busy_hi++;
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, output int k, output int bh);
        @(negedge clk);
        start = 1'b1;
        dividend = a;
        divisor = b;
        wait_done(-1, k, bh);
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom % 16)
            0: return 16'h0000;
            1: return 16'h0001;
            2: return 16'hFFFF;
            3: return 16'h8000;
            4: return 16'h7FFF;
            5: return 16'($urandom % 8);
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        int   k, bh, dn;
        res_t r;

        r = ref_div(16'd100, 16'd7, 1'b0);
        check("model 100/7 q", 32'(r.q), 32'd14);
        check("model 100/7 r", 32'(r.r), 32'd2);
        r = ref_div(16'hFFF9, 16'd2, 1'b1);
        check("model -7/2 q", 32'(r.q), 32'hFFFD);
        check("model -7/2 r", 32'(r.r), 32'hFFFF);
        r = ref_div(16'h8000, 16'hFFFF, 1'b1);
        check("model MIN/-1 q", 32'(r.q), 32'h8000);
        check("model MIN/-1 r", 32'(r.r), 32'h0000);

        repeat (3) @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            check($sformatf("reset busy[%0d]", m), 32'(busy[m]), 32'd0);
            check($sformatf("reset done[%0d]", m), 32'(done[m]), 32'd0);
            check($sformatf("reset quotient[%0d]", m), 32'(quo[m]), 32'd0);
            check($sformatf("reset remainder[%0d]", m), 32'(rem[m]), 32'd0);
            check($sformatf("reset dbz[%0d]", m), 32'(dbz[m]), 32'd0);
        end
        reset = 1'b0;

        run_op(16'd100, 16'd7, k, bh);
        $display("op 100/7: edges=%0d q=%0d r=%0d z=%0d", k, quo[0], rem[0], dbz[0]);
        check("100/7 latency", 32'(k), 32'd17);
        check("100/7 busy cycles", 32'(bh), 32'd16);
        check("100/7 busy low at done", 32'(busy[0]), 32'd0);
        check("100/7 q", 32'(quo[0]), 32'd14);
        check("100/7 r", 32'(rem[0]), 32'd2);
        check("100/7 dbz", 32'(dbz[0]), 32'd0);

        run_op(16'd5, 16'd0, k, bh);
        $display("op 5/0: edges=%0d q=0x%0h r=%0d z=%0d", k, quo[0], rem[0], dbz[0]);
        check("5/0 cycles after start", 32'(k + 1), 32'd1);
        check("5/0 busy never high", 32'(bh), 32'd0);
        check("5/0 q", 32'(quo[0]), 32'hFFFF);
        check("5/0 r", 32'(rem[0]), 32'd5);
        check("5/0 dbz", 32'(dbz[0]), 32'd1);

        run_op(16'hFFF9, 16'd2, k, bh);
        $display("op -7/2 signed: q=0x%0h r=0x%0h", quo[1], rem[1]);
        check("-7/2 q", 32'(quo[1]), 32'hFFFD);
        check("-7/2 r", 32'(rem[1]), 32'hFFFF);
        run_op(16'd7, 16'hFFFE, k, bh);
        $display("op 7/-2 signed: q=0x%0h r=0x%0h", quo[1], rem[1]);
        check("7/-2 q", 32'(quo[1]), 32'hFFFD);
        check("7/-2 r", 32'(rem[1]), 32'h0001);
        run_op(16'h8000, 16'hFFFF, k, bh);
        $display("op MIN/-1 signed: q=0x%0h r=0x%0h z=%0d", quo[1], rem[1], dbz[1]);
        check("MIN/-1 q", 32'(quo[1]), 32'h8000);
        check("MIN/-1 r", 32'(rem[1]), 32'h0000);
        check("MIN/-1 dbz", 32'(dbz[1]), 32'd0);

        // Start while busy is ignored; start in the done cycle is accepted.
        @(negedge clk);
        start = 1'b1;
        dividend = 16'hFFFF;
        divisor = 16'd1;
        wait_done(5, k, bh);
        $display("op FFFF/1 with ignored start: edges=%0d q=0x%0h r=%0d", k, quo[0], rem[0]);
        check("FFFF/1 latency", 32'(k), 32'd17);
        check("FFFF/1 q", 32'(quo[0]), 32'hFFFF);
        check("FFFF/1 r", 32'(rem[0]), 32'd0);
        start = 1'b1;
        dividend = 16'd3;
        divisor = 16'd3;
        wait_done(-1, k, bh);
        $display("op 3/3 back-to-back: edges=%0d q=%0d r=%0d", k, quo[0], rem[0]);
        check("3/3 latency", 32'(k), 32'd17);
        check("3/3 q", 32'(quo[0]), 32'd1);
        check("3/3 r", 32'(rem[0]), 32'd0);

        // Reset mid-operation aborts with no later done.
        @(negedge clk);
        start = 1'b1;
        dividend = 16'd1000;
        divisor = 16'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort busy", 32'(busy[0]), 32'd0);
        check("abort q", 32'(quo[0]), 32'd0);
        check("abort r", 32'(rem[0]), 32'd0);
        dn = 0;
        repeat (40) begin
            @(negedge clk);
            if (done[0] || done[1]) dn++;
        end
        $display("op 1000/3 aborted by reset: done pulses afterwards=%0d", dn);
        check("abort no done", 32'(dn), 32'd0);

        // Random sweep: operands change every cycle so busy-time re-sampling would be caught.
        repeat (30000) begin
            @(negedge clk);
            start = ($urandom % 3 == 0);
            dividend = pick_operand();
            divisor = pick_operand();
            reset = ($urandom % 3000 == 0);
            if (done[0])
                $display("rand done: u q=0x%0h r=0x%0h z=%0d | s q=0x%0h r=0x%0h z=%0d",
                         quo[0], rem[0], dbz[0], quo[1], rem[1], dbz[1]);
        end
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        repeat (25) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
